regfile_wb_arbiter: RTL and testbench

//  Shares the single write port of the 32x32 register file (x0 hardwired zero) among NUM_REQ

---
 rtl/regfile_pkg.sv | 16 +
 rtl/rr_arbiter.sv | 41 ++++
 rtl/regfile_wb_arbiter.sv | 74 +++++++
 tb/tb_regfile_wb_arbiter.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Register-file constants and helpers shared by the write-back arbiter,
// the register file itself and the decode stage.
package regfile_pkg;

  localparam int XLEN     = 32;
  localparam int REG_AW   = 5;
  localparam int NUM_REGS = 32;

  localparam logic [REG_AW-1:0] ZERO_REG = 5'd0;

  // x0 is hardwired to zero, so a write aimed at it must not raise the enable.
  function automatic logic writes_reg(input logic [REG_AW-1:0] rd);
    return rd != ZERO_REG;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: rotate the request vector so the slot after
// ptr sits at bit 0, pick the lowest set bit, then rotate the index back.
module rr_arbiter #(
  parameter int N  = 3,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx
);

  localparam logic [IW:0] N_W = (IW+1)'(N);

  logic [2*N-1:0] req_dbl;
  logic [N-1:0]   req_rot;
  logic [IW-1:0]  start;
  logic [IW-1:0]  sel;
  logic [IW:0]    sum;
  logic           found;

  assign req_dbl = {req, req};

  always_comb begin
    start   = (ptr == IW'(N-1)) ? '0 : ptr + 1'b1;
    req_rot = req_dbl[start +: N];
    sel     = '0;
    found   = 1'b0;
    for (int j = 0; j < N; j++) begin
      if (!found && req_rot[j]) begin
        found = 1'b1;
        sel   = IW'(j);
      end
    end
    // Undo the rotation: (start + sel) mod N without a divider.
    sum     = {1'b0, start} + {1'b0, sel};
    gnt_idx = (sum >= N_W) ? IW'(sum - N_W) : sum[IW-1:0];
    gnt     = found ? (N'(1) << gnt_idx) : '0;
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register-file write port among NUM_REQ
// write-back sources; the winning write is registered one clock after acceptance.
module regfile_wb_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int XLEN    = regfile_pkg::XLEN,
  parameter int REG_AW  = regfile_pkg::REG_AW,
  parameter int GID_W   = $clog2(NUM_REQ)
) (
  input  logic                      clk_w_i,
  input  logic                      res_w_i_l,
  input  logic [NUM_REQ-1:0]        req_valid_w_i,
  input  logic [NUM_REQ*REG_AW-1:0] req_rd_w_i,
  input  logic [NUM_REQ*XLEN-1:0]   req_data_w_i,
  output logic [NUM_REQ-1:0]        req_ready_w_o,
  input  logic                      stall_w_i,
  output logic [REG_AW-1:0]         wr_reg_w_o,
  output logic [XLEN-1:0]           wr_data_w_o,
  output logic                      reg_wr_flag_w_o,
  output logic [GID_W-1:0]          grant_id_w_o
);

  import regfile_pkg::*;

  logic [GID_W-1:0]   ptr_q;
  logic [GID_W-1:0]   gnt_idx;
  logic [NUM_REQ-1:0] gnt;
  logic               accept;
  logic [REG_AW-1:0]  sel_rd;
  logic [XLEN-1:0]    sel_data;

  rr_arbiter #(.N(NUM_REQ), .IW(GID_W)) u_rr (
    .req     (req_valid_w_i),
    .ptr     (ptr_q),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  // Handshake: a transfer happens at a posedge where valid[i] & ready[i]. Ready is
  // combinational, one-hot at most, only for a valid requester, and is held low
  // during stall and reset; requesters keep valid/rd/data stable until ready.
  assign accept        = res_w_i_l & ~stall_w_i & (|req_valid_w_i);
  assign req_ready_w_o = accept ? gnt : '0;

  always_comb begin
    sel_rd   = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_idx == GID_W'(i)) begin
        sel_rd   = req_rd_w_i[i*REG_AW +: REG_AW];
        sel_data = req_data_w_i[i*XLEN +: XLEN];
      end
    end
  end

  // Reset drops any registered write and points at the last slot so requester 0 wins first.
  always_ff @(posedge clk_w_i or negedge res_w_i_l) begin
    if (!res_w_i_l) begin
      ptr_q           <= GID_W'(NUM_REQ-1);
      wr_reg_w_o      <= '0;
      wr_data_w_o     <= '0;
      reg_wr_flag_w_o <= 1'b0;
      grant_id_w_o    <= '0;
    end else if (accept) begin
      ptr_q           <= gnt_idx;
      wr_reg_w_o      <= sel_rd;
      wr_data_w_o     <= sel_data;
      reg_wr_flag_w_o <= writes_reg(sel_rd);
      grant_id_w_o    <= gnt_idx;
    end else begin
      reg_wr_flag_w_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed cases with literal expectations, then a
// long random run, all checked every cycle against a queue/array reference model.
module tb_regfile_wb_arbiter;
  import regfile_pkg::*;

  localparam int N  = 3;
  localparam int GW = $clog2(N);

  logic                 clk, rst_n, stall, init_regs;
  logic [N-1:0]         valid, ready;
  logic [N*REG_AW-1:0]  rd_bus;
  logic [N*XLEN-1:0]    data_bus;
  logic [REG_AW-1:0]    wr_reg;
  logic [XLEN-1:0]      wr_data;
  logic                 wr_flag;
  logic [GW-1:0]        gid;

  int n_vec = 0;
  int n_err = 0;

  regfile_wb_arbiter #(.NUM_REQ(N), .XLEN(XLEN), .REG_AW(REG_AW), .GID_W(GW)) dut (
    .clk_w_i         (clk),
    .res_w_i_l       (rst_n),
    .req_valid_w_i   (valid),
    .req_rd_w_i      (rd_bus),
    .req_data_w_i    (data_bus),
    .req_ready_w_o   (ready),
    .stall_w_i       (stall),
    .wr_reg_w_o      (wr_reg),
    .wr_data_w_o     (wr_data),
    .reg_wr_flag_w_o (wr_flag),
    .grant_id_w_o    (gid)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, vectors=%0d", n_vec);
    $fatal(1, "watchdog expired");
  end

  // ---------------- register file fed by the DUT write port ----------------
  logic [XLEN-1:0]   rf [NUM_REGS];
  logic [REG_AW-1:0] ra0, ra1;
  logic [XLEN-1:0]   rdata0, rdata1;

  assign rdata0 = (ra0 == ZERO_REG) ? '0 : rf[ra0];
  assign rdata1 = (ra1 == ZERO_REG) ? '0 : rf[ra1];

  always @(posedge clk) begin
    if (init_regs) begin
      for (int i = 0; i < NUM_REGS; i++) rf[i] <= '0;
    end else if (wr_flag && wr_reg != ZERO_REG) begin
      rf[wr_reg] <= wr_data;
    end
  end

  // ---------------- reference model ----------------
  int                    m_ptr, m_gid, m_g, m_gi;
  logic                  m_flag;
  logic [REG_AW-1:0]     m_reg, m_rd;
  logic [XLEN-1:0]       m_data, m_dt;
  logic [N-1:0]          exp_ready;
  logic [XLEN-1:0]       m_regs [NUM_REGS];
  logic [REG_AW+XLEN-1:0] exp_q[$];

  // First valid requester after p, wrapping around; -1 when nobody is asking.
  function automatic int pick(input logic [N-1:0] v, input int p);
    for (int k = 1; k <= N; k++) begin
      if (v[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  always_comb begin
    m_g       = stall ? -1 : pick(valid, m_ptr);
    m_gi      = (m_g < 0) ? 0 : m_g;
    m_rd      = rd_bus[m_gi*REG_AW +: REG_AW];
    m_dt      = data_bus[m_gi*XLEN +: XLEN];
    exp_ready = (rst_n && m_g >= 0) ? (N'(1) << m_gi) : '0;
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ptr  <= N-1;
      m_gid  <= 0;
      m_flag <= 1'b0;
      m_reg  <= '0;
      m_data <= '0;
    end else if (m_g >= 0) begin
      m_ptr  <= m_g;
      m_gid  <= m_g;
      m_reg  <= m_rd;
      m_data <= m_dt;
      m_flag <= (m_rd != 0);
    end else begin
      m_flag <= 1'b0;
    end
  end

  always @(posedge clk) begin
    if (init_regs) begin
      for (int i = 0; i < NUM_REGS; i++) m_regs[i] <= '0;
    end else if (m_flag) begin
      m_regs[m_reg] <= m_data;
    end
  end

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    check("ready",    64'(ready),   64'(exp_ready));
    check("flag",     64'(wr_flag), 64'(m_flag));
    check("wr_reg",   64'(wr_reg),  64'(m_reg));
    check("wr_data",  64'(wr_data), 64'(m_data));
    check("grant_id", 64'(gid),     64'(m_gid));
    check("read0",    64'(rdata0),  64'(m_regs[ra0]));
    check("read1",    64'(rdata1),  64'(m_regs[ra1]));
    if (m_flag) exp_q.push_back({m_reg, m_data});
    if (wr_flag) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL sb_write: got write x%0d=%0h expected no write", wr_reg, wr_data);
      end else begin
        check("sb_write", 64'({wr_reg, wr_data}), 64'(exp_q.pop_front()));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [REG_AW-1:0] rd, input logic [XLEN-1:0] d);
    valid[i]                   = 1'b1;
    rd_bus[i*REG_AW +: REG_AW] = rd;
    data_bus[i*XLEN +: XLEN]   = d;
  endtask

  // Holds every pending request until it is granted, within a cycle budget.
  task automatic drain(input int budget);
    logic [N-1:0] rdy;
    int c;
    c = 0;
    while (valid != 0 && c < budget) begin
      @(negedge clk);
      rdy = ready;
      tick();
      valid = valid & ~rdy;
      c++;
    end
    n_vec++;
    if (valid != 0) begin
      n_err++;
      $display("FAIL drain: got valid=%b still pending expected 0 after %0d cycles", valid, budget);
    end
  endtask

  // Called just after a posedge: reset pulses low between edges.
  task automatic pulse_reset();
    #1 rst_n = 1'b0;
    #2 rst_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [N-1:0] rdy;
    rst_n = 1'b1; stall = 1'b0; valid = '0; rd_bus = '0; data_bus = '0;
    ra0 = '0; ra1 = '0; init_regs = 1'b1;
    #1 rst_n = 1'b0;

    @(negedge clk);
    check("rst_ready", 64'(ready), 64'd0);
    check("rst_flag",  64'(wr_flag), 64'd0);
    check("rst_gid",   64'(gid), 64'd0);
    tick(); tick();
    init_regs = 1'b0;
    rst_n     = 1'b1;

    // single request: same-cycle ready, write one edge later, readable the next
    set_req(0, 5'd5, 32'hDEADBEEF);
    @(negedge clk); check("t1_ready", 64'(ready), 64'(3'b001));
    tick(); valid = '0;
    @(negedge clk);
    check("t1_wr_reg", 64'(wr_reg), 64'd5);
    check("t1_flag",   64'(wr_flag), 64'd1);
    check("t1_data",   64'(wr_data), 64'hDEADBEEF);
    tick(); ra0 = 5'd5;
    @(negedge clk); check("t1_read_x5", 64'(rdata0), 64'hDEADBEEF);

    // rd=0 is consumed without a write
    tick(); set_req(1, 5'd0, 32'hFFFFFFFF);
    @(negedge clk); check("t3_ready", 64'(ready), 64'(3'b010));
    tick(); valid = '0; ra0 = 5'd0;
    @(negedge clk);
    check("t3_flag", 64'(wr_flag), 64'd0);
    check("t3_gid",  64'(gid), 64'd1);
    check("t3_read_x0", 64'(rdata0), 64'd0);

    // back-to-back grants 0,1,2 from a fresh pointer
    tick(); pulse_reset();
    set_req(0, 5'd1, 32'h11111111);
    set_req(1, 5'd2, 32'h22222222);
    set_req(2, 5'd3, 32'h33333333);
    @(negedge clk); check("t2_g0", 64'(ready), 64'(3'b001));
    tick(); valid[0] = 1'b0;
    @(negedge clk);
    check("t2_g1", 64'(ready), 64'(3'b010));
    check("t2_w1", 64'({wr_flag, wr_reg}), 64'({1'b1, 5'd1}));
    tick(); valid[1] = 1'b0;
    @(negedge clk);
    check("t2_g2", 64'(ready), 64'(3'b100));
    check("t2_w2", 64'({wr_flag, wr_reg}), 64'({1'b1, 5'd2}));
    tick(); valid[2] = 1'b0;
    @(negedge clk); check("t2_w3", 64'({wr_flag, wr_reg}), 64'({1'b1, 5'd3}));
    tick(); ra0 = 5'd1; ra1 = 5'd2;
    @(negedge clk);
    check("t2_x1", 64'(rdata0), 64'h11111111);
    check("t2_x2", 64'(rdata1), 64'h22222222);
    ra0 = 5'd3; #1;
    check("t2_x3", 64'(rdata0), 64'h33333333);

    // same rd from two requesters, pointer at 2: req0 then req2, last one sticks
    tick();
    set_req(0, 5'd7, 32'hAAAA0001);
    set_req(2, 5'd7, 32'hBBBB0002);
    ra0 = 5'd7;
    @(negedge clk); check("t4_g0", 64'(ready), 64'(3'b001));
    tick(); valid[0] = 1'b0;
    @(negedge clk);
    check("t4_g2", 64'(ready), 64'(3'b100));
    check("t4_dA", 64'(wr_data), 64'hAAAA0001);
    tick(); valid = '0;
    @(negedge clk); check("t4_dB", 64'(wr_data), 64'hBBBB0002);
    tick();
    @(negedge clk); check("t4_x7", 64'(rdata0), 64'hBBBB0002);

    // stall freezes grants and the pointer
    tick(); stall = 1'b1;
    set_req(0, 5'd8,  $urandom());
    set_req(1, 5'd9,  $urandom());
    set_req(2, 5'd10, $urandom());
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("t5_stall_ready", 64'(ready), 64'd0);
      check("t5_stall_flag",  64'(wr_flag), 64'd0);
      tick();
    end
    stall = 1'b0;
    @(negedge clk); check("t5_resume", 64'(ready), 64'(3'b001));
    tick(); valid[0] = 1'b0;
    drain(10);

    // asynchronous reset mid-burst
    set_req(0, 5'd11, 32'h0B0B0B0B);
    set_req(1, 5'd12, 32'h0C0C0C0C);
    set_req(2, 5'd13, 32'h0D0D0D0D);
    @(negedge clk); check("t6_g0", 64'(ready), 64'(3'b001));
    tick(); valid[0] = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check("t6_rst_flag",  64'(wr_flag), 64'd0);
    check("t6_rst_ready", 64'(ready), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    set_req(0, 5'd11, 32'h0B0B0B0B);
    @(negedge clk); check("t6_after_rst", 64'(ready), 64'(3'b001));
    tick(); valid[0] = 1'b0;
    drain(10);

    // random run: valid/rd/data/stall/read addresses, rare reset pulses
    for (int c = 0; c < 10000; c++) begin
      @(negedge clk);
      rdy = ready;
      tick();
      valid = valid & ~rdy;
      for (int i = 0; i < N; i++) begin
        if (!valid[i] && $urandom_range(0, 1) == 1)
          set_req(i, ($urandom_range(0, 5) == 0) ? 5'd0 : REG_AW'($urandom_range(0, 31)), $urandom());
      end
      stall = ($urandom_range(0, 7) == 0);
      ra0   = REG_AW'($urandom_range(0, 31));
      ra1   = REG_AW'($urandom_range(0, 31));
      if ($urandom_range(0, 499) == 0) pulse_reset();
    end

    stall = 1'b0;
    valid = '0;
    repeat (3) tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
